// File: rtl/sm_test_mem_resp_sink_pkg.sv
// Shared definitions for the test memory response sink: response message layout,
// LFSR polynomial and error-counter width.
`ifndef SM_MEM_RESP_MSG_NBITSX
// Response carries type, opaque, test, len and data; the address width is accepted for
// signature compatibility with the request macros but contributes no bits.
`define SM_MEM_RESP_MSG_NBITSX(o_, a_, d_) (3 + (o_) + 2 + $clog2((d_) / 8) + (d_) + 0 * (a_))
`endif

package sm_test_mem_resp_sink_pkg;

  localparam int unsigned c_mem_type_nbits = 3;
  localparam int unsigned c_mem_test_nbits = 2;

  typedef enum logic [c_mem_type_nbits-1:0] {
    MEM_TYPE_READ  = 3'd0,
    MEM_TYPE_WRITE = 3'd1,
    MEM_TYPE_INIT  = 3'd2,
    MEM_TYPE_AMO   = 3'd3
  } mem_type_e;

  localparam logic [31:0] c_lfsr_taps     = 32'h8020_0003;
  localparam int unsigned c_err_cnt_nbits = 16;

  typedef logic [c_err_cnt_nbits-1:0] err_cnt_t;
  localparam err_cnt_t c_err_cnt_max = '1;

  function automatic int unsigned resp_len_nbits(input int unsigned data_nbits);
    return $clog2(data_nbits / 8);
  endfunction

  // Field LSB positions, data field at the bottom of the message.
  function automatic int unsigned resp_data_lsb();
    return 0;
  endfunction

  function automatic int unsigned resp_len_lsb(input int unsigned data_nbits);
    return data_nbits;
  endfunction

  function automatic int unsigned resp_test_lsb(input int unsigned data_nbits);
    return data_nbits + resp_len_nbits(data_nbits);
  endfunction

  function automatic int unsigned resp_opaque_lsb(input int unsigned data_nbits);
    return resp_test_lsb(data_nbits) + c_mem_test_nbits;
  endfunction

  function automatic int unsigned resp_type_lsb(input int unsigned opaque_nbits,
                                                input int unsigned data_nbits);
    return resp_opaque_lsb(data_nbits) + opaque_nbits;
  endfunction

  // Right-shifting Galois step for x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state);
    logic [31:0] shifted;
    shifted = {1'b0, state[31:1]};
    return state[0] ? (shifted ^ c_lfsr_taps) : shifted;
  endfunction

endpackage

// File: rtl/sm_test_mem_resp_sink_if.sv
// Valid/ready response stream from the random-delay test memory into its sink.
interface sm_test_mem_resp_sink_if #(
  parameter int unsigned p_msg_nbits = `SM_MEM_RESP_MSG_NBITSX(8, 32, 32)
);
  logic                   val;
  logic                   rdy;
  logic [p_msg_nbits-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/sm_rand_rdy_gen.sv
// Random stall generator: free-running LFSR plus a delay down-counter loaded on each
// accepted transfer; rdy_ok is high once the drawn stall has elapsed.
module sm_rand_rdy_gen
  import sm_test_mem_resp_sink_pkg::*;
#(
  parameter logic [31:0] p_seed = 32'hB0A5_F00D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] max_delay,
  input  logic        fire,
  input  logic        enable,
  output logic        rdy_ok
);

  logic [31:0] lfsr_q, lfsr_d;
  logic [15:0] delay_cnt_q, delay_cnt_d;
  logic [16:0] delay_mod;
  logic [15:0] delay_draw;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);

    // Stall range is 0..min(max_delay, 65535).
    delay_mod  = (max_delay[31:16] != 16'd0) ? 17'h1_0000
                                             : ({1'b0, max_delay[15:0]} + 17'd1);
    delay_draw = 16'({1'b0, lfsr_q[15:0]} % delay_mod);

    delay_cnt_d = delay_cnt_q;
    if (fire) begin
      delay_cnt_d = (max_delay == 32'd0) ? 16'd0 : delay_draw;
    end else if (delay_cnt_q != 16'd0) begin
      delay_cnt_d = delay_cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q      <= p_seed;
      delay_cnt_q <= '0;
    end else begin
      lfsr_q      <= lfsr_d;
      delay_cnt_q <= delay_cnt_d;
    end
  end

  assign rdy_ok = enable && (delay_cnt_q == 16'd0);

endmodule

// File: rtl/sm_test_mem_resp_sink.sv
// Test sink for the random-delay test memory: random back-pressure and in-order checking
// against a preloaded table. Build option SM_TEST_MEM_RESP_SINK_MASK_EN adds a compare mask.
module sm_test_mem_resp_sink
  import sm_test_mem_resp_sink_pkg::*;
#(
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_addr_nbits   = 32,
  parameter int unsigned p_data_nbits   = 32,
  parameter int unsigned p_max_msgs     = 1024,
  parameter logic [31:0] p_seed         = 32'hB0A5_F00D,
  localparam int unsigned c_resp_nbits  =
    `SM_MEM_RESP_MSG_NBITSX(p_opaque_nbits, p_addr_nbits, p_data_nbits),
  localparam int unsigned c_idx_nbits   = $clog2(p_max_msgs) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              max_delay,
  input  logic [c_idx_nbits-1:0]   num_msgs,
  input  logic                     load_en,
  input  logic [c_idx_nbits-2:0]   load_idx,
  input  logic [c_resp_nbits-1:0]  load_msg,
`ifdef SM_TEST_MEM_RESP_SINK_MASK_EN
  input  logic [c_resp_nbits-1:0]  load_mask,
`endif
  sm_test_mem_resp_sink_if.slave   in_if,
  output logic                     done,
  output err_cnt_t                 err_count,
  output logic                     err_valid,
  output logic [c_idx_nbits-1:0]   first_err_idx,
  output logic                     extra_msg
);

  typedef logic [c_resp_nbits-1:0] resp_t;
  typedef logic [c_idx_nbits-1:0]  idx_t;

  resp_t exp_mem_q [p_max_msgs];
`ifdef SM_TEST_MEM_RESP_SINK_MASK_EN
  resp_t mask_mem_q [p_max_msgs];
`endif

  idx_t     idx_q, idx_d;
  err_cnt_t err_count_q, err_count_d;
  logic     err_valid_q, err_valid_d;
  idx_t     first_err_idx_q, first_err_idx_d;
  logic     extra_msg_q, extra_msg_d;

  logic                   rdy_ok;
  logic                   fire;
  logic                   mismatch;
  logic                   load_wr;
  logic [c_idx_nbits-2:0] rd_idx;
  resp_t                  exp_msg;
  resp_t                  cmp_mask;

  assign done      = (idx_q == num_msgs);
  assign in_if.rdy = !reset && rdy_ok;
  assign fire      = in_if.val && in_if.rdy;

  sm_rand_rdy_gen #(
    .p_seed (p_seed)
  ) u_rdy_gen (
    .clk       (clk),
    .reset     (reset),
    .max_delay (max_delay),
    .fire      (fire),
    .enable    (!done),
    .rdy_ok    (rdy_ok)
  );

  // Entries below idx have already been checked; rewriting them is ignored so a late
  // harness load cannot disturb a replay after reset. Same-entry load and compare in one
  // cycle compares against the old contents because the read is ahead of the write edge.
  assign rd_idx  = idx_q[c_idx_nbits-2:0];
  assign exp_msg = exp_mem_q[rd_idx];
  assign load_wr = load_en && ({1'b0, load_idx} >= idx_q);

  always_ff @(posedge clk) begin
    if (load_wr) begin
      exp_mem_q[load_idx] <= load_msg;
    end
  end

`ifdef SM_TEST_MEM_RESP_SINK_MASK_EN
  always_ff @(posedge clk) begin
    if (load_wr) begin
      mask_mem_q[load_idx] <= load_mask;
    end
  end

  assign cmp_mask = mask_mem_q[rd_idx];
`else
  assign cmp_mask = '1;
`endif

  assign mismatch = |((in_if.msg ^ exp_msg) & cmp_mask);

  always_comb begin
    idx_d           = idx_q;
    err_count_d     = err_count_q;
    err_valid_d     = err_valid_q;
    first_err_idx_d = first_err_idx_q;
    extra_msg_d     = extra_msg_q || (done && in_if.val);

    if (fire) begin
      idx_d = idx_q + 1'b1;
      if (mismatch) begin
        if (err_count_q != c_err_cnt_max) begin
          err_count_d = err_count_q + 1'b1;
        end
        if (!err_valid_q) begin
          err_valid_d     = 1'b1;
          first_err_idx_d = idx_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q           <= '0;
      err_count_q     <= '0;
      err_valid_q     <= 1'b0;
      first_err_idx_q <= '0;
      extra_msg_q     <= 1'b0;
    end else begin
      idx_q           <= idx_d;
      err_count_q     <= err_count_d;
      err_valid_q     <= err_valid_d;
      first_err_idx_q <= first_err_idx_d;
      extra_msg_q     <= extra_msg_d;
    end
  end

  assign err_count     = err_count_q;
  assign err_valid     = err_valid_q;
  assign first_err_idx = first_err_idx_q;
  assign extra_msg     = extra_msg_q;

endmodule
